mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-port memory arbiter. Lets NUM_PORTS processor cores share one single-port synchronous data memory. Uses per-port request/acknowledge handshakes, work-conserving round-robin arbitration and a read-return pipeline that routes each read result back to the port that issued it. Sits between the core load/store units and the shared data RAM, and replaces the fixed two-slot multiplexer clocked on a separate fast clock.

## Interface
- NUM_PORTS, 4: number of core ports; ≥2, need not be a power of two.
- ADDR_W, 12: memory address width.
- DATA_W, 16: memory data width.
- RD_LAT, 1: memory read latency in cycles from the mem_addr cycle to valid mem_rdata; ≥1.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_PORTS  per-port access request.
- we  in  NUM_PORTS  per-port write enable: 1 = write, 0 = read.
- addr  in  NUM_PORTS*ADDR_W  packed addresses; port p occupies [p*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  packed write data, same packing.
- ack  out  NUM_PORTS  one-hot or zero; combinational grant; transfer occurs on a clk edge where req[p]&ack[p].
- rvalid  out  NUM_PORTS  one-hot or zero; read data for port p is valid this cycle.
- rdata  out  DATA_W  shared read-return data, qualified by rvalid.
- mem_en  out  1  memory command valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- Handshake
  - Port p holds req, we, addr and wdata stable until it sees ack[p]=1 at a clk edge.
  - A port may keep req high for back-to-back accesses.
  - Dropping req before ack is legal and cancels the request.
- Arbitration
  - Combinational round-robin from priority pointer ptr (width clog2(NUM_PORTS)).
  - The first requesting port scanning ptr, ptr+1, …, wrapping NUM_PORTS-1→0, receives ack.
  - On a transfer to port g, ptr becomes g+1, wrapping to 0 after NUM_PORTS-1.
  - With no request: ack=0 and ptr holds.
- Command register
  - On a transfer, mem_en=1 on the next cycle, with mem_we/mem_addr/mem_wdata from port g.
  - Otherwise mem_en=0 and mem_we=0; address and data hold their last values.
- Read-return pipeline
  - Shift register of depth RD_LAT+1 carrying {valid, port id}, loaded on each read transfer.
  - Writes are not entered and return nothing.
  - At the output stage, mem_rdata is registered into rdata and rvalid[id] pulses for one cycle.
- Throughput: one transfer per cycle. A single continuously requesting port is acked every cycle.
- Reset (async, any time)
  - ack is combinational and follows req&ptr; with ptr=0 it is 0 whenever no req.
  - Registered outputs clear: rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ptr=0 and the pipeline is cleared. In-flight reads are discarded and never return rvalid.
  - ack stays 0 while rst_n=0.

## Timing
- Transfer at edge ending cycle T.
- Memory command: mem_en/mem_we/mem_addr/mem_wdata valid in cycle T+1.
- Read data: mem_rdata sampled in T+1+RD_LAT; rvalid/rdata valid in T+2+RD_LAT (T+3 at RD_LAT=1).
- Reads return in issue order; a rvalid pulse may coincide with a new ack to any port.
- Write then read to the same address from any ports in consecutive transfers: the read returns the written data, provided the RAM is write-first or has separate-cycle write.
- Simultaneous requests from all ports with ptr=0: acks go 0,1,…,N-1 on consecutive cycles.

## Configuration
- MEM_ARB_TDM_EN
  - Defined: fixed time-division mode.
    - A slot counter advances every cycle 0→NUM_PORTS-1→0 regardless of requests.
    - Only port==slot can be acked, and only if req[slot].
    - An empty slot gives mem_en=0 next cycle.
    - Latency is deterministic at ≤NUM_PORTS cycles to ack.
    - The slot counter resets to 0.
  - Undefined: work-conserving round-robin as described above. Pipeline and timing are identical in both modes.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 reads in flight -> all outputs 0 immediately; no rvalid after release; first ack after release goes to the lowest requesting port.
- Single port: port 2 writes 0xBEEF to 0x123 then reads 0x123 back-to-back -> ack[2] two consecutive cycles; mem_en high in T+1 and T+2; rvalid[2] with rdata=0xBEEF at T+4 (RD_LAT=1).
- All four ports request continuously -> ack sequence 0,1,2,3,0,…; each port gets exactly 1/4 of cycles; mem_en=1 every cycle.
- Ports 1 and 3 only, ptr=2 -> ack 3 then 1 then 3, with no idle cycle between them.
- Reads from ports 0,1,2 on consecutive cycles, RD_LAT=3 -> rvalid[0],[1],[2] on consecutive cycles with matching data, 5 cycles after each ack.
- MEM_ARB_TDM_EN defined, only port 3 requesting from slot 0 -> ack[3] after 3 idle cycles (mem_en=0 in those), then every 4th cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets NUM_PORTS cores share one single-port synchronous RAM.
//
// Each port has a req/ack handshake. ack is combinational, and a transfer
// happens on any clk edge where req[p] & ack[p]. The winning command is
// registered onto the mem_* bus for the next cycle. Each read sends its port id
// down a return pipeline. That pipeline lines up with the RAM read latency, so
// the read data is steered back to the port that issued it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req/we [NUM_PORTS]    per-port request and write enable (1 = write)
//   addr / wdata          packed per-port address / write data, port p at [p*W +: W]
//   ack [NUM_PORTS]       one-hot grant (combinational)
//   rvalid [NUM_PORTS]    one-hot read-return strobe, qualifies rdata
//   rdata                 shared read-return data
//   mem_en/we/addr/wdata  registered RAM command
//   mem_rdata             RAM read data, RD_LAT cycles after the command
//
// Build option MEM_ARB_TDM_EN: when this macro is defined, the round-robin
// arbiter is replaced by fixed time-division slots. A slot counter cycles
// 0..NUM_PORTS-1 every clock, and only port==slot can be granted.
module mem_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          ack,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [PW-1:0] id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic gnt_vld;
  id_t  gnt_id;
  logic xfer;
  cmd_t sel;

`ifdef MEM_ARB_TDM_EN
  // The slot counter is free-running, so an idle slot is simply wasted.
  id_t slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot <= '0;
    else        slot <= (int'(slot) == NUM_PORTS-1) ? '0 : slot + id_t'(1);
  end

  always_comb begin
    gnt_id  = slot;
    gnt_vld = req[slot];
  end
`else
  id_t ptr;

  // The scan runs from the farthest offset down to ptr. The last hit written
  // is the first requester at or after ptr, wrapping past NUM_PORTS-1.
  // idx has one extra bit so that a non-power-of-two wrap cannot alias.
  always_comb begin : rr
    logic [PW:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (req[idx[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (xfer) ptr <= (int'(gnt_id) == NUM_PORTS-1) ? '0 : gnt_id + id_t'(1);
  end
`endif

  // Gate the grant with rst_n so that no ack is seen while reset is held.
  assign xfer = gnt_vld & rst_n;

  always_comb begin
    sel.we    = we[gnt_id];
    sel.addr  = addr[gnt_id*ADDR_W +: ADDR_W];
    sel.wdata = wdata[gnt_id*DATA_W +: DATA_W];
  end

  // Read-return pipeline. Stage 0 is loaded on the transfer edge.
  // Stage RD_LAT lines up with the cycle in which mem_rdata is valid.
  logic [RD_LAT:0]         vld_pipe;
  logic [RD_LAT:0][PW-1:0] id_pipe;
  logic [NUM_PORTS-1:0]    ret_oh;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign ack[p]    = xfer && (gnt_id == id_t'(p));
    assign ret_oh[p] = vld_pipe[RD_LAT] && (id_pipe[RD_LAT] == id_t'(p));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (xfer) begin
      mem_en    <= 1'b1;
      mem_we    <= sel.we;
      mem_addr  <= sel.addr;
      mem_wdata <= sel.wdata;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], xfer & ~sel.we};
      id_pipe  <= {id_pipe[RD_LAT-1:0], gnt_id};
      rvalid   <= ret_oh;
      if (vld_pipe[RD_LAT]) rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks two mem_arbiter instances, one with RD_LAT=1 and one
// with RD_LAT=3. Both instances share the same port stimulus, and each one
// drives its own behavioural RAM. A transaction-level reference model checks
// every output of both instances on every cycle. Directed tables and short
// sequences add explicit checks for the corner cases.
module tb_mem_arbiter;
  localparam int N = 4, AW = 12, DW = 16;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC = 8192, NRAND = 3000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  req = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;

  logic [N-1:0]  ack_o [2];
  logic [N-1:0]  rvalid_o [2];
  logic [DW-1:0] rdata_o [2];
  logic [DW-1:0] mem_rdata [2];
  logic [DW-1:0] mem_wdata [2];
  logic [AW-1:0] mem_addr [2];
  logic          mem_en [2];
  logic          mem_we [2];

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a) ^ 16'h5A5A;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : 3;
    logic [DW-1:0] ram [DEPTH];
    bit            written [DEPTH];
    logic [DW-1:0] dl [L];

    // Write-first single-port RAM model. Unwritten words read as init_val.
    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) begin
        ram[mem_addr[k]]     <= mem_wdata[k];
        written[mem_addr[k]] <= 1'b1;
      end
      dl[0] <= (mem_en[k] && !mem_we[k]) ?
               (written[mem_addr[k]] ? ram[mem_addr[k]] : init_val(int'(mem_addr[k]))) : '0;
      for (int s = 1; s < L; s++) dl[s] <= dl[s-1];
    end
    assign mem_rdata[k] = dl[L-1];

    mem_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack_o[k]), .rvalid(rvalid_o[k]), .rdata(rdata_o[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]));
  end

  // Reference model. Every transfer is logged by cycle number. A read is
  // expected back 2+RD_LAT cycles later, carrying the shadow-memory value
  // that was current at the time of its transfer.
  int            ptr_m = 0, slot_m = 0, cyc = 0;
  logic          cmd_en_m = 0, cmd_we_m = 0;
  logic [AW-1:0] cmd_a_m = '0;
  logic [DW-1:0] cmd_d_m = '0;
  logic [DW-1:0] shadow [DEPTH];
  bit            sh_w [DEPTH];
  bit            rd_vld [MAXC];
  int            rd_port [MAXC];
  logic [DW-1:0] rd_data [MAXC];
  logic [DW-1:0] last_d [2];
  logic [N-1:0]  last_ack = '0;

  always @(negedge clk) begin : model
    int g, lat, ic, a;
    logic [N-1:0] ea, erv;
    if (!rst_n) begin
      ptr_m = 0; slot_m = 0;
      cmd_en_m = 0; cmd_we_m = 0; cmd_a_m = '0; cmd_d_m = '0;
      last_d[0] = '0; last_d[1] = '0;
      for (int j = (cyc > 10 ? cyc - 10 : 0); j <= cyc; j++) rd_vld[j] = 1'b0;
    end
    g = -1;
    if (rst_n) begin
`ifdef MEM_ARB_TDM_EN
      if (req[slot_m]) g = slot_m;
`else
      for (int i = 0; i < N; i++)
        if (g < 0 && req[(ptr_m + i) % N]) g = (ptr_m + i) % N;
`endif
    end
    ea = '0;
    if (g >= 0) ea[g] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 3;
      ic  = cyc - 2 - lat;
      erv = '0;
      if (rst_n && ic >= 0 && rd_vld[ic]) begin
        erv[rd_port[ic]] = 1'b1;
        last_d[k] = rd_data[ic];
      end
      cmp($sformatf("ack[%0d]", k),       32'(ack_o[k]),     32'(ea));
      cmp($sformatf("rvalid[%0d]", k),    32'(rvalid_o[k]),  32'(erv));
      cmp($sformatf("rdata[%0d]", k),     32'(rdata_o[k]),   32'(last_d[k]));
      cmp($sformatf("mem_en[%0d]", k),    32'(mem_en[k]),    32'(cmd_en_m));
      cmp($sformatf("mem_we[%0d]", k),    32'(mem_we[k]),    32'(cmd_we_m));
      cmp($sformatf("mem_addr[%0d]", k),  32'(mem_addr[k]),  32'(cmd_a_m));
      cmp($sformatf("mem_wdata[%0d]", k), 32'(mem_wdata[k]), 32'(cmd_d_m));
    end
    if (rst_n) begin
      rd_vld[cyc] = 1'b0;
      if (g >= 0) begin
        a        = int'(addr[g*AW +: AW]);
        cmd_en_m = 1'b1;
        cmd_we_m = we[g];
        cmd_a_m  = addr[g*AW +: AW];
        cmd_d_m  = wdata[g*DW +: DW];
        if (we[g]) begin
          shadow[a] = cmd_d_m;
          sh_w[a]   = 1'b1;
        end else begin
          rd_vld[cyc]  = 1'b1;
          rd_port[cyc] = g;
          rd_data[cyc] = sh_w[a] ? shadow[a] : init_val(a);
        end
        ptr_m = (g + 1) % N;
      end else begin
        cmd_en_m = 1'b0;
        cmd_we_m = 1'b0;
      end
      slot_m = (slot_m + 1) % N;
    end
    last_ack = ea;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] ack;
  } vec_t;

  initial begin : stim
    vec_t tbl [16];
    logic [N-1:0] pend;
    bit dropped;
    int dens;

    tbl[0]  = '{4'b1111, 4'b0001}; tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100}; tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1010, 4'b0010}; tbl[5]  = '{4'b1010, 4'b1000};
    tbl[6]  = '{4'b1010, 4'b0010}; tbl[7]  = '{4'b1010, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000}; tbl[9]  = '{4'b0100, 4'b0100};
    tbl[10] = '{4'b0001, 4'b0001}; tbl[11] = '{4'b0001, 4'b0001};
    tbl[12] = '{4'b1001, 4'b1000}; tbl[13] = '{4'b1001, 4'b0001};
    tbl[14] = '{4'b0110, 4'b0010}; tbl[15] = '{4'b0110, 4'b0100};

    repeat (2) @(posedge clk);
    #1;
`ifdef MEM_ARB_TDM_EN
    // Only port 3 is requesting, starting from slot 0.
    req = 4'b1000; we = '0; addr[3*AW +: AW] = 12'h050;
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      smp();
      cmp("tdm_ack", 32'(ack_o[0]), (c % 4 == 3) ? 32'h8 : 32'h0);
      if (c > 0) cmp("tdm_en", 32'(mem_en[0]), (c % 4 == 0) ? 32'h1 : 32'h0);
      step();
    end
    req = '0;
`else
    rst_n = 1'b1;
    for (int p = 0; p < N; p++) addr[p*AW +: AW] = AW'(32 + p);
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req;
      smp();
      cmp($sformatf("tbl%0d_ack", i), 32'(ack_o[0]), 32'(tbl[i].ack));
      step();
    end
    req = '0;
    step();

    // Port 2: write 0xBEEF to 0x123, then read it back on the next cycle.
    req = 4'b0100; we = 4'b0100;
    addr[2*AW +: AW] = 12'h123; wdata[2*DW +: DW] = 16'hBEEF;
    smp(); cmp("sp_ack_wr", 32'(ack_o[0]), 32'h4);
    step(); we = '0;
    smp(); cmp("sp_ack_rd", 32'(ack_o[0]), 32'h4);
    cmp("sp_en1", 32'(mem_en[0]), 32'h1); cmp("sp_we1", 32'(mem_we[0]), 32'h1);
    cmp("sp_addr1", 32'(mem_addr[0]), 32'h123); cmp("sp_wd1", 32'(mem_wdata[0]), 32'hBEEF);
    step(); req = '0;
    smp(); cmp("sp_en2", 32'(mem_en[0]), 32'h1); cmp("sp_we2", 32'(mem_we[0]), 32'h0);
    step(); smp(); cmp("sp_rv3", 32'(rvalid_o[0]), 32'h0);
    step(); smp(); cmp("sp_rv4", 32'(rvalid_o[0]), 32'h4); cmp("sp_rd4", 32'(rdata_o[0]), 32'hBEEF);
    step(); smp(); cmp("sp_rv5_l3", 32'(rvalid_o[1]), 32'h0);
    step(); smp(); cmp("sp_rv6_l3", 32'(rvalid_o[1]), 32'h4); cmp("sp_rd6_l3", 32'(rdata_o[1]), 32'hBEEF);
    step();

    // A write from port 3 moves ptr back to 0. Ports 0,1,2 then read on
    // consecutive cycles, and each read returns 5 cycles later at RD_LAT=3.
    req = 4'b1000; we = 4'b1000; addr[3*AW +: AW] = 12'h200; wdata[3*DW +: DW] = 16'h1234;
    smp(); cmp("b_pre", 32'(ack_o[0]), 32'h8);
    step(); we = '0;
    for (int p = 0; p < 3; p++) addr[p*AW +: AW] = AW'(16 + p);
    req = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      smp(); cmp("b_ack", 32'(ack_o[1]), 32'(1 << i));
      step(); req[i] = 1'b0;
    end
    step(); step();
    for (int i = 0; i < 3; i++) begin
      smp();
      cmp("b_rv_l3", 32'(rvalid_o[1]), 32'(1 << i));
      cmp("b_rd_l3", 32'(rdata_o[1]), 32'(init_val(16 + i)));
      step();
    end

    // Put two reads in flight, then assert reset in the middle of the stream.
    addr[0*AW +: AW] = 12'h030; addr[1*AW +: AW] = 12'h031;
    req = 4'b0011;
    smp(); cmp("c_ack0", 32'(ack_o[0]), 32'h1);
    step(); req = 4'b0010;
    smp(); cmp("c_ack1", 32'(ack_o[0]), 32'h2);
    step();
    req = 4'b1111; rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      cmp("c_rst_ack", 32'(ack_o[k]), 32'h0);
      cmp("c_rst_rv", 32'(rvalid_o[k]), 32'h0);
      cmp("c_rst_rd", 32'(rdata_o[k]), 32'h0);
      cmp("c_rst_en", 32'(mem_en[k]), 32'h0);
      cmp("c_rst_we", 32'(mem_we[k]), 32'h0);
      cmp("c_rst_addr", 32'(mem_addr[k]), 32'h0);
      cmp("c_rst_wd", 32'(mem_wdata[k]), 32'h0);
    end
    step(); smp(); cmp("c_rst_hold_ack", 32'(ack_o[0]), 32'h0);
    step();
    req = 4'b1100; we = 4'b1100;
    addr[2*AW +: AW] = 12'h040; wdata[2*DW +: DW] = 16'hCAFE;
    addr[3*AW +: AW] = 12'h041; wdata[3*DW +: DW] = 16'hF00D;
    rst_n = 1'b1;
    smp(); cmp("c_first", 32'(ack_o[0]), 32'h4);
    step(); req = '0; we = '0;
    for (int i = 0; i < 8; i++) begin
      smp();
      cmp("c_no_rv0", 32'(rvalid_o[0]), 32'h0);
      cmp("c_no_rv1", 32'(rvalid_o[1]), 32'h0);
      step();
    end
`endif

    // Random traffic that obeys the handshake: a port holds its request until
    // ack, occasionally cancels, and may re-request back to back.
    pend = '0;
    for (int c = 0; c < NRAND; c++) begin
      dens = ((c / 500) % 3 == 0) ? 100 : ((c / 500) % 3 == 1) ? 50 : 15;
      for (int p = 0; p < N; p++) begin
        dropped = 1'b0;
        if (pend[p] && last_ack[p]) pend[p] = 1'b0;
        else if (pend[p] && $urandom_range(0, 15) == 0) begin
          pend[p] = 1'b0;
          dropped = 1'b1;
        end
        if (!pend[p] && !dropped && $urandom_range(1, 100) <= dens) begin
          pend[p] = 1'b1;
          we[p] = 1'($urandom_range(0, 1));
          addr[p*AW +: AW]  = AW'($urandom_range(0, 15));
          wdata[p*DW +: DW] = DW'($urandom);
        end
      end
      req = pend;
      step();
    end
    req = '0;
    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
